sram_rr_arbiter: RTL and testbench
==================================

SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width in bits (multiple of 8).
REQ-003 SHALL have parameter N_WORDS, default 1024, SRAM depth; AW = $clog2(N_WORDS), BW = DATA_WIDTH/8.
REQ-004 SHALL have port: clk_i  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port: rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: req_i  in  NUM_PORTS  per-port request.
REQ-007 SHALL have port: we_i  in  NUM_PORTS  per-port write enable.
REQ-008 SHALL have port: addr_i  in  NUM_PORTS x AW  per-port word address.
REQ-009 SHALL have port: wdata_i  in  NUM_PORTS x DATA_WIDTH  per-port write data.
REQ-010 SHALL have port: be_i  in  NUM_PORTS x BW  per-port byte enables.
REQ-011 SHALL have port: gnt_o  out  NUM_PORTS  per-port grant, one-hot or zero.
REQ-012 SHALL have port: rvalid_o  out  NUM_PORTS  per-port response valid.
REQ-013 SHALL have port: rdata_o  out  DATA_WIDTH  shared read data.
REQ-014 SHALL have ports: mem_req_o/mem_we_o (1), mem_addr_o (AW), mem_wdata_o (DATA_WIDTH), mem_be_o (BW), all out; mem_rdata_i (DATA_WIDTH) in; single-port 1-cycle-latency SRAM side.

Function
REQ-015 SHALL grant at most one port per cycle; gnt_o combinational from req_i and priority pointer, same cycle as request.
REQ-016 SHALL pick the first requesting port scanning from index ptr+1 upward, modulo NUM_PORTS (round robin).
REQ-017 SHALL update ptr to the granted index on each grant cycle; no grant -> ptr holds.
REQ-018 SHALL drive mem_req_o = |req_i; mem_we_o/addr/wdata/be = the granted port's fields; when no grant, mem_we_o=0, other mem fields=0.
REQ-019 SHALL assert rvalid_o[i] exactly one cycle after gnt_o[i], for reads and writes alike (write acknowledge).
REQ-020 SHALL drive rdata_o = mem_rdata_i when a registered read response is valid, else all zeros; write responses give rdata_o=0.
REQ-021 SHALL keep a granted request's fields sampled only in the grant cycle; requester may change or drop them the next cycle.
REQ-022 SHALL sustain one grant per cycle back-to-back; simultaneous grant of port j and response for port i in same cycle SHALL be supported.
REQ-023 SHALL never grant a port twice in a row while another port requests continuously (bounded wait <= NUM_PORTS-1 grants).
REQ-024 SHALL treat a single requesting port as granted every cycle regardless of ptr.
REQ-025 SHALL be combinational-loop free: gnt_o SHALL not depend on gnt_o or rvalid_o.

Reset
REQ-026 SHALL on rst_ni low set ptr = NUM_PORTS-1 (port 0 highest priority first), clear response registers; rvalid_o=0, rdata_o=0 asynchronously.
REQ-027 SHALL discard a response pending when reset asserts mid-operation; no rvalid_o after reset release for pre-reset grants.
REQ-028 SHALL, during reset, keep gnt_o combinational per REQ-015 with reset ptr; requesters SHALL not rely on grants while rst_ni low.

Verification
REQ-029 SHALL test: after reset, req_i=2'b11 both reads -> gnt_o=01, then 10, then 01; rvalid_o follows each one cycle later.
REQ-030 SHALL test: port 1 writes 0xDEADBEEF be=4'hF addr 5, next cycle port 0 reads addr 5 -> rvalid_o[0] with rdata_o=0xDEADBEEF.
REQ-031 SHALL test: port 0 writes 0x11223344 be=4'b0101 over 0x00000000 at addr 3, read back -> 0x00220044.
REQ-032 SHALL test: only port 1 requests 4 consecutive cycles -> gnt_o=10 every cycle, 4 rvalid_o[1] pulses.
REQ-033 SHALL test: grant read on port 0, assert rst_ni low next cycle before edge -> rvalid_o stays 0, ptr back to reset value.
REQ-034 SHALL test: NUM_PORTS=4 all requesting 8 cycles -> grant order 0,1,2,3,0,1,2,3, mem_req_o high throughout.

Source files
------------

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency SRAM among NUM_PORTS requesters.
// Grants are combinational; responses (read data or write acknowledge) return one cycle later.
module sram_rr_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_WORDS    = 1024,
  localparam int unsigned AW = $clog2(N_WORDS),
  localparam int unsigned BW = DATA_WIDTH / 8
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_PORTS-1:0]                req_i,
  input  logic [NUM_PORTS-1:0]                we_i,
  input  logic [NUM_PORTS-1:0][AW-1:0]        addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_PORTS-1:0][BW-1:0]        be_i,
  output logic [NUM_PORTS-1:0]                gnt_o,
  output logic [NUM_PORTS-1:0]                rvalid_o,
  output logic [DATA_WIDTH-1:0]               rdata_o,
  output logic                                mem_req_o,
  output logic                                mem_we_o,
  output logic [AW-1:0]                       mem_addr_o,
  output logic [DATA_WIDTH-1:0]               mem_wdata_o,
  output logic [BW-1:0]                       mem_be_o,
  input  logic [DATA_WIDTH-1:0]               mem_rdata_i
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0]        ptr_q;
  logic [NUM_PORTS-1:0] rvalid_q;
  logic                 rd_q;
  logic                 gnt_any;
  logic [PW-1:0]        gnt_idx;
  int                   cand;

  // Scan from ptr+1 upward with wrap; first requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int off = 1; off <= int'(NUM_PORTS); off++) begin
      cand = (int'(ptr_q) + off) % int'(NUM_PORTS);
      if (!gnt_any && req_i[PW'(cand)]) begin
        gnt_any = 1'b1;
        gnt_idx = PW'(cand);
      end
    end
  end

  always_comb begin
    gnt_o       = '0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    mem_req_o   = |req_i;
    if (gnt_any) begin
      gnt_o       = NUM_PORTS'(1) << gnt_idx;
      mem_we_o    = we_i[gnt_idx];
      mem_addr_o  = addr_i[gnt_idx];
      mem_wdata_o = wdata_i[gnt_idx];
      mem_be_o    = be_i[gnt_idx];
    end
  end

  // Priority pointer and one-cycle response tracking; reset drops any pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= PW'(NUM_PORTS - 1);
      rvalid_q <= '0;
      rd_q     <= 1'b0;
    end else begin
      if (gnt_any) begin
        ptr_q <= gnt_idx;
      end
      rvalid_q <= gnt_o;
      rd_q     <= gnt_any & ~mem_we_o;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rd_q ? mem_rdata_i : '0;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter: 2-port instance with a behavioural SRAM,
// plus a 4-port instance for the fairness rotation.
module tb_sram_rr_arbiter;

  logic clk;
  logic rst_n;

  logic [1:0]       req, we, gnt, rvalid;
  logic [1:0][9:0]  addr;
  logic [1:0][31:0] wdata;
  logic [1:0][3:0]  be;
  logic [31:0]      rdata;
  logic             mem_req, mem_we;
  logic [9:0]       mem_addr;
  logic [31:0]      mem_wdata, mem_rdata;
  logic [3:0]       mem_be;

  logic [3:0]       req4, we4, gnt4, rvalid4;
  logic [3:0][3:0]  addr4;
  logic [3:0][31:0] wdata4;
  logic [3:0][3:0]  be4;
  logic [31:0]      rdata4, mem_wdata4;
  logic             mem_req4, mem_we4;
  logic [3:0]       mem_addr4, mem_be4;

  logic [31:0] sram [0:1023];
  logic [3:0]  exp_order [0:7];

  int n_checks = 0;
  int n_pass   = 0;

  sram_rr_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(32), .N_WORDS(1024)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  sram_rr_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32), .N_WORDS(16)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req4), .we_i(we4), .addr_i(addr4),
    .wdata_i(wdata4), .be_i(be4), .gnt_o(gnt4), .rvalid_o(rvalid4), .rdata_o(rdata4),
    .mem_req_o(mem_req4), .mem_we_o(mem_we4), .mem_addr_o(mem_addr4),
    .mem_wdata_o(mem_wdata4), .mem_be_o(mem_be4), .mem_rdata_i(32'h0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM with byte enables and one cycle read latency.
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0; be4 = '0;
    tick; tick;
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_gnt_idle", 32'(gnt), 32'h0);
    check("rst_memwe_idle", 32'(mem_we), 32'h0);
    check("rst_memaddr_idle", 32'(mem_addr), 32'h0);
    req = 2'b11;
    #1 check("rst_gnt_both", 32'(gnt), 32'h1);
    req = 2'b00;
    tick;
    rst_n = 1'b1;
    tick;

    // Round robin between two readers.
    req = 2'b11; we = 2'b00; addr[0] = 10'd7; addr[1] = 10'd9;
    #1 check("rr_gnt0", 32'(gnt), 32'h1);
    check("rr_addr0", 32'(mem_addr), 32'd7);
    check("rr_memreq", 32'(mem_req), 32'h1);
    tick;
    check("rr_rv0", 32'(rvalid), 32'h1);
    check("rr_gnt1", 32'(gnt), 32'h2);
    check("rr_addr1", 32'(mem_addr), 32'd9);
    tick;
    check("rr_rv1", 32'(rvalid), 32'h2);
    check("rr_gnt2", 32'(gnt), 32'h1);
    tick;
    check("rr_rv2", 32'(rvalid), 32'h1);
    req = 2'b00;
    #1 check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_memreq", 32'(mem_req), 32'h0);
    tick;
    check("idle_rv", 32'(rvalid), 32'h0);

    // Partial byte-enable write over a cleared word.
    req = 2'b01; we = 2'b01; addr[0] = 10'd3; wdata[0] = 32'h0; be[0] = 4'hF;
    tick;
    check("clr_ack", 32'(rvalid), 32'h1);
    check("clr_ack_rdata", rdata, 32'h0);
    wdata[0] = 32'h11223344; be[0] = 4'b0101;
    #1 check("be_mem_be", 32'(mem_be), 32'h5);
    tick;
    check("be_ack", 32'(rvalid), 32'h1);
    we = 2'b00;
    tick;
    check("be_rv", 32'(rvalid), 32'h1);
    check("be_rdata", rdata, 32'h00220044);

    // Port 1 writes, port 0 reads it back next cycle.
    req = 2'b10; we = 2'b10; addr[1] = 10'd5; wdata[1] = 32'hDEADBEEF; be[1] = 4'hF;
    #1 check("wr1_gnt", 32'(gnt), 32'h2);
    check("wr1_memwe", 32'(mem_we), 32'h1);
    tick;
    check("wr1_ack", 32'(rvalid), 32'h2);
    check("wr1_ack_rdata", rdata, 32'h0);
    req = 2'b01; we = 2'b00; addr[0] = 10'd5;
    #1 check("rd0_gnt", 32'(gnt), 32'h1);
    tick;
    check("rd0_rv", 32'(rvalid), 32'h1);
    check("rd0_rdata", rdata, 32'hDEADBEEF);

    // Lone requester is granted every cycle.
    req = 2'b10; we = 2'b00; addr[1] = 10'd5;
    for (int i = 0; i < 4; i++) begin
      #1 check("solo_gnt", 32'(gnt), 32'h2);
      tick;
      check("solo_rv", 32'(rvalid), 32'h2);
      check("solo_rdata", rdata, 32'hDEADBEEF);
    end
    req = 2'b00;
    tick;
    check("solo_end_rv", 32'(rvalid), 32'h0);

    // Reset mid-operation drops the pending response and restores the pointer.
    req = 2'b01; addr[0] = 10'd5;
    tick;
    check("pre_rst_rv", 32'(rvalid), 32'h1);
    #1 check("pre_rst_gnt", 32'(gnt), 32'h1);
    #2 rst_n = 1'b0;
    #1 check("async_rv_clr", 32'(rvalid), 32'h0);
    check("async_rdata_clr", rdata, 32'h0);
    req = 2'b00;
    tick;
    check("in_rst_rv", 32'(rvalid), 32'h0);
    req = 2'b11;
    #1 check("rst_ptr_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    tick;
    rst_n = 1'b1;
    tick;
    check("post_rst_rv", 32'(rvalid), 32'h0);
    req = 2'b11;
    #1 check("post_rst_gnt", 32'(gnt), 32'h1);
    req = 2'b00;

    // Four-port rotation with every port requesting.
    req4 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1 check("rr4_gnt", 32'(gnt4), 32'(exp_order[i]));
      check("rr4_memreq", 32'(mem_req4), 32'h1);
      tick;
      check("rr4_rv", 32'(rvalid4), 32'(exp_order[i]));
    end
    req4 = 4'h0;
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
